// File: rtl/instr_encoder_loader.sv
// Symbolic instruction encoder and instruction-memory loader.
// Packs class+fields into MIPS words and streams them to memory.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_end,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_class,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     busy,
  output logic                     full,
  output logic                     err,
  output logic                     done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_done;
  logic          r_end_pend;

  logic          w_legal;
  fmt_t          w_fmt;
  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_rd;
  logic [4:0]    w_sh;
  logic [31:0]   w_enc;

  logic          w_accept;
  logic          w_bad;
  logic          w_close;
  logic          w_wr_done;
  logic [CW-1:0] w_count_inc;

  // Field selection; fields a class does not use are forced to zero
  always_comb begin
    w_legal = 1'b1;
    w_fmt   = FMT_R;
    w_op    = 6'h00;
    w_fn    = 6'h00;
    w_rs    = in_rs;
    w_rt    = in_rt;
    w_rd    = in_rd;
    w_sh    = 5'd0;
    unique case (in_class)
      5'd0:  w_fn = 6'h20;
      5'd1:  w_fn = 6'h21;
      5'd2:  w_fn = 6'h22;
      5'd3:  w_fn = 6'h23;
      5'd4:  w_fn = 6'h24;
      5'd5:  w_fn = 6'h25;
      5'd6:  w_fn = 6'h26;
      5'd7:  w_fn = 6'h27;
      5'd8:  w_fn = 6'h2a;
      5'd9:  w_fn = 6'h2b;
      5'd10: begin w_fn = 6'h00; w_rs = 5'd0; w_sh = in_shamt; end
      5'd11: begin w_fn = 6'h02; w_rs = 5'd0; w_sh = in_shamt; end
      5'd12: begin w_fn = 6'h03; w_rs = 5'd0; w_sh = in_shamt; end
      5'd13: begin w_fn = 6'h08; w_rt = 5'd0; w_rd = 5'd0; end
      5'd14: begin w_fn = 6'h09; w_rt = 5'd0; end
      5'd15: begin w_op = 6'h1c; w_fn = 6'h02; end
      5'd16: begin w_fmt = FMT_I; w_op = 6'h23; end
      5'd17: begin w_fmt = FMT_I; w_op = 6'h2b; end
      5'd18: begin w_fmt = FMT_I; w_op = 6'h0f; w_rs = 5'd0; end
      5'd19: begin w_fmt = FMT_I; w_op = 6'h08; end
      5'd20: begin w_fmt = FMT_I; w_op = 6'h09; end
      5'd21: begin w_fmt = FMT_I; w_op = 6'h0c; end
      5'd22: begin w_fmt = FMT_I; w_op = 6'h0a; end
      5'd23: begin w_fmt = FMT_I; w_op = 6'h0b; end
      5'd24: begin w_fmt = FMT_I; w_op = 6'h04; end
      5'd25: begin w_fmt = FMT_I; w_op = 6'h05; end
      5'd26: begin w_fmt = FMT_I; w_op = 6'h06; w_rt = 5'd0; end
      5'd27: begin w_fmt = FMT_I; w_op = 6'h07; w_rt = 5'd0; end
      5'd28: begin w_fmt = FMT_I; w_op = 6'h01; w_rt = 5'd0; end
      5'd29: begin w_fmt = FMT_J; w_op = 6'h02; end
      5'd30: begin w_fmt = FMT_J; w_op = 6'h03; end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (w_fmt)
      FMT_I:   w_enc = {w_op, w_rs, w_rt, in_imm};
      FMT_J:   w_enc = {w_op, in_target};
      default: w_enc = {w_op, w_rs, w_rt, w_rd, w_sh, w_fn};
    endcase
  end

  assign w_count_inc = r_count + 1'b1;

  // load_start overrides every state, abandoning any in-flight write
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_bad     = 1'b0;
    w_close   = 1'b0;
    w_wr_done = 1'b0;
    if (load_start) begin
      w_next = LOAD;
    end else begin
      unique case (r_state)
        IDLE: w_next = IDLE;
        LOAD: begin
          if (in_valid && w_legal) begin
            w_accept = 1'b1;
            w_next   = WRITE;
          end else if (in_valid) begin
            w_bad = 1'b1;
            if (load_end) begin
              w_close = 1'b1;
              w_next  = IDLE;
            end
          end else if (load_end) begin
            w_close = 1'b1;
            w_next  = IDLE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            w_wr_done = 1'b1;
            if (w_count_inc == DEPTH_C) begin
              w_next = FULL;
            end else if (r_end_pend || load_end) begin
              w_close = 1'b1;
              w_next  = IDLE;
            end else begin
              w_next = LOAD;
            end
          end
        end
        FULL: begin
          if (load_end || r_end_pend) begin
            w_close = 1'b1;
            w_next  = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'd0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_end_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_close;
      if (load_start) begin
        r_addr     <= BASE_ADDR;
        r_count    <= '0;
        r_err      <= 1'b0;
        r_end_pend <= 1'b0;
      end else begin
        if (w_accept) begin
          r_wdata    <= w_enc;
          r_end_pend <= load_end;
        end
        if (w_bad) r_err <= 1'b1;
        if (r_state == WRITE && load_end) r_end_pend <= 1'b1;
        if (w_wr_done) begin
          r_addr  <= r_addr + 32'd4;
          r_count <= w_count_inc;
        end
        if (w_close) r_end_pend <= 1'b0;
      end
    end
  end

  assign in_ready   = (r_state == LOAD);
  assign mem_we     = (r_state == WRITE);
  assign busy       = (r_state != IDLE);
  assign full       = (r_state == FULL);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_count;
  assign err        = r_err;
  assign done       = r_done;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder: accepts symbolic instructions (instruction class plus operand fields) over a valid/ready handshake.
- Assembles each into a 32-bit MIPS word covering exactly the subset the single-cycle datapath decodes.
- Writes the words sequentially into instruction memory through a write port with a ready handshake.
- Used by the testbench/boot path to load programs before the CPU is released from reset.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of first word written per load session
DEPTH, 256, maximum words per session (power of 2, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_start  input  1  pulse: begin session at BASE_ADDR, clear count and err
load_end  input  1  pulse: close session
in_valid  input  1  instruction fields valid
in_ready  output  1  block accepts fields this cycle
in_class  input  5  instruction class code (see Behaviour)
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field
in_shamt  input  5  shift amount
in_imm  input  16  immediate / branch offset
in_target  input  26  jump target field
mem_we  output  1  write request
mem_ready  input  1  memory accepts write this cycle
mem_addr  output  32  byte address (word aligned)
mem_wdata  output  32  encoded instruction
word_count  output  $clog2(DEPTH)+1  words written this session
busy  output  1  session open (state != IDLE)
full  output  1  DEPTH words written
err  output  1  sticky: an illegal class was presented
done  output  1  one-cycle pulse when a session closes

Behaviour:
- Reset (async): state IDLE; all outputs 0; mem_addr=BASE_ADDR; word_count=0.
- Class codes and encodings (unused fields forced to 0):
  - R-type, op 00, word = {op,rs,rt,rd,shamt,funct}: 0 add/20, 1 addu/21, 2 sub/22, 3 subu/23, 4 and/24, 5 or/25, 6 xor/26, 7 nor/27, 8 slt/2a, 9 sltu/2b (shamt=0).
  - Shifts: 10 sll/00, 11 srl/02, 12 sra/03 (rs=0).
  - Jumps via register: 13 jr/08 (rt=rd=shamt=0); 14 jalr/09 (rt=shamt=0).
  - 15 mul: op 1c, funct 02, shamt=0.
  - I-type, word = {op,rs,rt,imm}: 16 lw/23, 17 sw/2b, 18 lui/0f (rs=0), 19 addi/08, 20 addiu/09, 21 andi/0c, 22 slti/0a, 23 sltiu/0b, 24 beq/04, 25 bne/05, 26 blez/06 (rt=0), 27 bgtz/07 (rt=0), 28 bltz/01 (rt=0).
  - J-type, word = {op,target}: 29 j/02, 30 jal/03.
  - 31 is illegal.
- FSM IDLE / LOAD / WRITE / FULL:
  - IDLE: in_ready=0. load_start -> LOAD; mem_addr=BASE_ADDR, word_count=0, err=0.
  - LOAD: in_ready=1. On in_valid with a legal class: register the encoded word -> WRITE. On in_valid with class 31: set err, discard, stay in LOAD. load_end with no in_valid -> IDLE, done=1 for one cycle.
  - WRITE: in_ready=0; mem_we=1; mem_addr/mem_wdata held stable until mem_ready. On mem_ready: mem_addr+=4, word_count+=1. If new count==DEPTH -> FULL; else if load_end is pending -> IDLE with done pulse; else -> LOAD.
  - FULL: full=1, in_ready=0, mem_we=0. load_end -> IDLE with done pulse (full clears). load_start -> new session.
- Simultaneous events:
  - load_end during WRITE is latched and honoured after the write completes; the in-flight word is never dropped.
  - load_end and in_valid in the same LOAD cycle: the word is accepted first, then the session closes after its write.
  - load_start while busy restarts the session immediately: an in-flight write is abandoned (mem_we drops the next cycle), pending load_end is cleared, and done is not pulsed.
- Latency: accept -> mem_we asserted next cycle. Minimum 2 cycles per word (back-to-back when mem_ready is tied high).
- mem_addr wraps modulo 2^32 (no error raised).
- busy=1 in LOAD/WRITE/FULL.

Test Plan:
- load_start; add rd=3 rs=1 rt=2, mem_ready=1 -> mem_we at 0x0 with 0x00221820; word_count=1.
- lw rt=8 rs=29 imm=4, then sll rd=2 rt=3 shamt=4 (rs input=7) -> 0x8FA80004 at 0x0, 0x00031100 at 0x4 (rs forced 0).
- beq rs=1 rt=2 imm=FFFF and j target=0x0100000, with mem_ready low 3 cycles -> addr/data held stable while stalled; words 0x1022FFFF, 0x08100000.
- class 31 presented -> err=1, no mem_we, count unchanged; the next legal word is still written; load_start clears err.
- DEPTH=4: stream 5 words -> full=1 after the 4th write with in_ready=0; load_end -> done pulse, busy=0.
- Assert reset mid-WRITE -> all outputs 0 asynchronously; load_end coincident with in_valid -> word written, then done pulse.
